pwm_deadtime_gen: RTL and testbench

- Compare/output stage placed directly downstream of the free-running counter.
- Consumes the counter's count value and overflow flag each clock.
- Produces a complementary PWM pair (high-side/low-side) with programmable dead-time.
- Duty changes are double-buffered so they take effect only at a period boundary.

---
 rtl/pwm_deadtime_gen_pkg.sv | 16 +
 rtl/pwm_deadtime_gen_if.sv | 31 +++
 rtl/pwm_deadtime_gen_deadtime_timer.sv | 27 ++
 rtl/pwm_deadtime_gen.sv | 142 ++++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared definitions for the PWM dead-time output stage: default widths and
// the compare-stage FSM state encoding.
package pwm_deadtime_gen_pkg;

  localparam int DEFAULT_COUNTER_SIZE = 32;
  localparam int DEFAULT_DT_SIZE      = 8;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LOW     = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HIGH    = 3'd3,
    ST_DT_FALL = 3'd4
  } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime_gen_if.sv
// Counter-side inputs, duty programming and PWM outputs of the dead-time stage.
// The master modport drives the stage, the slave modport is the stage itself.
interface pwm_deadtime_gen_if
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE,
  parameter int DT_SIZE      = DEFAULT_DT_SIZE
);

  logic                    enable;
  logic [COUNTER_SIZE-1:0] count;
  logic                    overflow;
  logic                    duty_wr;
  logic [COUNTER_SIZE-1:0] duty_in;
  logic [DT_SIZE-1:0]      deadtime;
  logic                    pwm_hi;
  logic                    pwm_lo;
  logic [COUNTER_SIZE-1:0] duty_active;
  logic                    update_done;

  modport master (
    output enable, count, overflow, duty_wr, duty_in, deadtime,
    input  pwm_hi, pwm_lo, duty_active, update_done
  );

  modport slave (
    input  enable, count, overflow, duty_wr, duty_in, deadtime,
    output pwm_hi, pwm_lo, duty_active, update_done
  );

endinterface

// File: rtl/pwm_deadtime_gen_deadtime_timer.sv
// Dead-time down-counter: load on entry to a dead-time state, decrement to
// zero, and flag the last dead cycle when the count reaches 1.
module pwm_deadtime_gen_deadtime_timer #(
  parameter int DT_SIZE = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DT_SIZE-1:0] load_val,
  output logic               expired
);

  logic [DT_SIZE-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == DT_SIZE'(1));

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM output stage with double-buffered duty and programmable
// dead-time, fed by an upstream free-running counter.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_OFF     | stage disabled, both outputs inactive
// ST_LOW     | low-side driven
// ST_DT_RISE | dead time before turning the high side on
// ST_HIGH    | high-side driven
// ST_DT_FALL | dead time before turning the low side on
module pwm_deadtime_gen
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int COUNTER_SIZE   = DEFAULT_COUNTER_SIZE,
  parameter int DT_SIZE        = DEFAULT_DT_SIZE,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input logic               clk,
  input logic               reset_n,
  pwm_deadtime_gen_if.slave bus
);

  logic [COUNTER_SIZE-1:0] duty_pending;
  logic [COUNTER_SIZE-1:0] duty_active_q;
  logic                    update_pending;
  logic                    update_done_q;
  logic                    transfer;
  logic                    raw;
  logic                    dt_zero;
  logic                    dt_load;
  logic                    dt_expired;
  logic                    pwm_hi_q;
  logic                    pwm_lo_q;
  pwm_state_t              state;
  pwm_state_t              state_nxt;

  assign transfer = bus.enable && bus.overflow && update_pending;
  assign raw      = (bus.count < duty_active_q);
  assign dt_zero  = (bus.deadtime == '0);

  // A write coinciding with a transfer stays pending; the transfer takes the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_pending   <= '0;
      duty_active_q  <= '0;
      update_pending <= 1'b0;
      update_done_q  <= 1'b0;
    end else begin
      update_done_q <= transfer;
      if (transfer) begin
        duty_active_q <= duty_pending;
      end
      if (bus.duty_wr) begin
        duty_pending   <= bus.duty_in;
        update_pending <= 1'b1;
      end else if (transfer) begin
        update_pending <= 1'b0;
      end
    end
  end

  pwm_deadtime_gen_deadtime_timer #(
    .DT_SIZE (DT_SIZE)
  ) u_deadtime_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (dt_load),
    .load_val (bus.deadtime),
    .expired  (dt_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dt_load   = 1'b0;
    if (!bus.enable) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          if (dt_zero) begin
            state_nxt = raw ? ST_HIGH : ST_LOW;
          end else begin
            state_nxt = raw ? ST_DT_RISE : ST_DT_FALL;
            dt_load   = 1'b1;
          end
        end
        ST_LOW: begin
          if (raw) begin
            state_nxt = dt_zero ? ST_HIGH : ST_DT_RISE;
            dt_load   = !dt_zero;
          end
        end
        ST_DT_RISE: begin
          if (!raw) begin
            state_nxt = ST_LOW;
          end else if (dt_expired) begin
            state_nxt = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (!raw) begin
            state_nxt = dt_zero ? ST_LOW : ST_DT_FALL;
            dt_load   = !dt_zero;
          end
        end
        ST_DT_FALL: begin
          if (raw) begin
            state_nxt = ST_HIGH;
          end else if (dt_expired) begin
            state_nxt = ST_LOW;
          end
        end
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_hi_q <= OUT_ACTIVE_LOW;
      pwm_lo_q <= OUT_ACTIVE_LOW;
    end else begin
      pwm_hi_q <= (state_nxt == ST_HIGH) ^ OUT_ACTIVE_LOW;
      pwm_lo_q <= (state_nxt == ST_LOW) ^ OUT_ACTIVE_LOW;
    end
  end

  assign bus.pwm_hi      = pwm_hi_q;
  assign bus.pwm_lo      = pwm_lo_q;
  assign bus.duty_active = duty_active_q;
  assign bus.update_done = update_done_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Scoreboard bench for pwm_deadtime_gen: an active-high and an active-low
// instance share stimulus and are checked against one behavioural model.
module tb_pwm_deadtime_gen;

  localparam int CW = 32;
  localparam int DW = 8;

  typedef struct packed {
    logic          hi;
    logic          lo;
    logic [CW-1:0] act;
    logic          done;
  } exp_t;

  logic clk;
  logic reset_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pwm_deadtime_gen_if #(.COUNTER_SIZE(CW), .DT_SIZE(DW)) bus0 ();
  pwm_deadtime_gen_if #(.COUNTER_SIZE(CW), .DT_SIZE(DW)) bus1 ();

  assign bus1.enable   = bus0.enable;
  assign bus1.count    = bus0.count;
  assign bus1.overflow = bus0.overflow;
  assign bus1.duty_wr  = bus0.duty_wr;
  assign bus1.duty_in  = bus0.duty_in;
  assign bus1.deadtime = bus0.deadtime;

  pwm_deadtime_gen #(.COUNTER_SIZE(CW), .DT_SIZE(DW), .OUT_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  pwm_deadtime_gen #(.COUNTER_SIZE(CW), .DT_SIZE(DW), .OUT_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  int n_assert = 0;
  int n_fail   = 0;
  int n_hi, n_lo, n_off, n_done;
  exp_t sb[$];
  exp_t me;

  logic [CW-1:0] m_pend, m_act;
  logic          m_upd, m_dir;
  int            m_side;  // 0 disabled, 1 low, 2 high, 3 dead time
  int            m_left;
  int            g_cnt;
  logic [DW-1:0] g_dt;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_act = '0; m_upd = 1'b0; m_dir = 1'b0; m_side = 0; m_left = 0;
  endtask

  task automatic model_step(output exp_t e);
    logic raw, xfer;
    raw  = bus0.count < m_act;
    xfer = bus0.enable && bus0.overflow && m_upd;
    if (xfer) m_act = m_pend;
    if (bus0.duty_wr) begin
      m_pend = bus0.duty_in; m_upd = 1'b1;
    end else if (xfer) begin
      m_upd = 1'b0;
    end
    if (!bus0.enable) begin
      m_side = 0; m_left = 0;
    end else if (m_left > 0) begin
      if (raw != m_dir) begin
        m_side = raw ? 2 : 1; m_left = 0;
      end else if (m_left == 1) begin
        m_side = m_dir ? 2 : 1; m_left = 0;
      end else begin
        m_left--;
      end
    end else if (m_side == 0 || (raw && m_side == 1) || (!raw && m_side == 2)) begin
      if (bus0.deadtime == '0) begin
        m_side = raw ? 2 : 1;
      end else begin
        m_side = 3; m_left = int'(bus0.deadtime); m_dir = raw;
      end
    end
    e.hi = (m_side == 2); e.lo = (m_side == 1); e.act = m_act; e.done = xfer;
  endtask

  // Called at a negedge: drive inputs, push the post-edge expectation, wait a cycle.
  task automatic tick(input logic en, input logic [CW-1:0] cnt, input logic ovf,
                      input logic wr, input logic [CW-1:0] din, input logic [DW-1:0] dt);
    exp_t e;
    bus0.enable = en; bus0.count = cnt; bus0.overflow = ovf;
    bus0.duty_wr = wr; bus0.duty_in = din; bus0.deadtime = dt;
    model_step(e);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic step_cnt(input logic wr, input logic [CW-1:0] din);
    tick(1'b1, CW'(g_cnt), g_cnt == 255, wr, din, g_dt);
    g_cnt = (g_cnt + 1) % 256;
  endtask

  task automatic run_period(input int wa, input logic [CW-1:0] va, input int wb, input logic [CW-1:0] vb);
    for (int i = 0; i < 256; i++) begin
      if (i == wa)      step_cnt(1'b1, va);
      else if (i == wb) step_cnt(1'b1, vb);
      else              step_cnt(1'b0, '0);
    end
  endtask

  task automatic clear_tally();
    n_hi = 0; n_lo = 0; n_off = 0; n_done = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("pwm_hi", bus0.pwm_hi, me.hi);
      chk("pwm_lo", bus0.pwm_lo, me.lo);
      chk("duty_active", bus0.duty_active, me.act);
      chk("update_done", bus0.update_done, me.done);
      chk("pwm_hi_al", bus1.pwm_hi, !me.hi);
      chk("pwm_lo_al", bus1.pwm_lo, !me.lo);
    end
    chk("never_both", bus0.pwm_hi & bus0.pwm_lo, 0);
    chk("never_both_al", (!bus1.pwm_hi) & (!bus1.pwm_lo), 0);
    if (bus0.pwm_hi) n_hi++;
    if (bus0.pwm_lo) n_lo++;
    if (!bus0.pwm_hi && !bus0.pwm_lo) n_off++;
    if (bus0.update_done) n_done++;
  end

  initial begin
    bus0.enable = 1'b0; bus0.count = '0; bus0.overflow = 1'b0;
    bus0.duty_wr = 1'b0; bus0.duty_in = '0; bus0.deadtime = '0;
    g_cnt = 0; g_dt = 8'd4;
    model_reset();
    clear_tally();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_hi", bus0.pwm_hi, 0);
    chk("rst_lo", bus0.pwm_lo, 0);
    chk("rst_duty", bus0.duty_active, 0);
    chk("rst_done", bus0.update_done, 0);
    chk("rst_hi_al", bus1.pwm_hi, 1);
    chk("rst_lo_al", bus1.pwm_lo, 1);
    reset_n = 1'b1;

    // Duty written while disabled is still accepted.
    tick(1'b0, '0, 1'b0, 1'b1, CW'(128), g_dt);
    tick(1'b0, '0, 1'b0, 1'b0, '0, g_dt);

    // duty 128, deadtime 4: steady-state period tallies.
    g_cnt = 0;
    run_period(-1, '0, -1, '0);
    run_period(-1, '0, -1, '0);
    clear_tally();
    run_period(-1, '0, -1, '0);
    chk("dt4_hi_cycles", n_hi, 124);
    chk("dt4_lo_cycles", n_lo, 124);
    chk("dt4_off_cycles", n_off, 8);

    // Double buffering, last write wins, write coinciding with transfer.
    clear_tally();
    run_period(100, CW'(100), -1, '0);
    chk("db_done_pulses", n_done, 1);
    chk("db_duty100", bus0.duty_active, 100);
    run_period(10, CW'(50), 20, CW'(80));
    chk("db_last_wins", bus0.duty_active, 80);
    run_period(5, CW'(90), 255, CW'(60));
    chk("db_same_cycle_old", bus0.duty_active, 90);
    run_period(-1, '0, -1, '0);
    chk("db_same_cycle_new", bus0.duty_active, 60);

    // Dead-time abort: raw high for 3 clks inside a 10-clk dead time.
    g_dt = 8'd10;
    repeat (15) tick(1'b1, CW'(200), 1'b0, 1'b0, '0, g_dt);
    clear_tally();
    repeat (3) tick(1'b1, CW'(10), 1'b0, 1'b0, '0, g_dt);
    repeat (5) tick(1'b1, CW'(200), 1'b0, 1'b0, '0, g_dt);
    chk("abort_no_hi", n_hi, 0);
    chk("abort_lo_back", n_lo, 5);

    // Edge duties with deadtime 0.
    g_dt = 8'd0;
    tick(1'b1, CW'(200), 1'b0, 1'b1, '0, g_dt);
    tick(1'b1, CW'(200), 1'b1, 1'b0, '0, g_dt);
    g_cnt = 0;
    clear_tally();
    run_period(-1, '0, -1, '0);
    chk("duty0_no_hi", n_hi, 0);
    tick(1'b1, CW'(200), 1'b0, 1'b1, 32'hFFFF_FFFF, g_dt);
    tick(1'b1, CW'(200), 1'b1, 1'b0, '0, g_dt);
    repeat (3) tick(1'b1, CW'(5), 1'b0, 1'b0, '0, g_dt);
    clear_tally();
    repeat (2) tick(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, g_dt);
    repeat (3) tick(1'b1, CW'(5), 1'b0, 1'b0, '0, g_dt);
    chk("dutymax_lo", n_lo, 2);
    chk("dutymax_hi", n_hi, 3);

    // Enable drop while high, then re-enable with deadtime 3.
    tick(1'b0, CW'(5), 1'b0, 1'b0, '0, g_dt);
    chk("disable_hi_off", bus0.pwm_hi, 0);
    clear_tally();
    repeat (5) tick(1'b1, CW'(5), 1'b0, 1'b0, '0, 8'd3);
    chk("reenable_hi", n_hi, 2);
    chk("reenable_off", n_off, 3);

    // Async reset between edges while high; pending write must be lost.
    tick(1'b1, CW'(5), 1'b0, 1'b1, CW'(77), 8'd3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_hi", bus0.pwm_hi, 0);
    chk("async_lo", bus0.pwm_lo, 0);
    chk("async_hi_al", bus1.pwm_hi, 1);
    chk("async_duty", bus0.duty_active, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (2) tick(1'b1, CW'(5), 1'b1, 1'b0, '0, 8'd0);
    repeat (2) tick(1'b1, CW'(5), 1'b0, 1'b0, '0, 8'd0);
    chk("post_rst_duty", bus0.duty_active, 0);

    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
